// File: rtl/gate_selftest.sv
// gate_selftest: exhaustive self-test sequencer for a 16-output combinational gate board.
//
// Drives every combination of the three gate inputs {C,B,A} in turn. After each change it waits
// SETTLE_CYCLES clocks, then compares the (double-synchronised) gate outputs against the ideal
// truth table for one cycle. Mismatches accumulate in a sticky per-gate mask.
//
// Ports
//   clk_i         single clock, rising edge
//   rst_i         synchronous, active-high reset
//   start_i       one-cycle request to begin a sweep (honoured only when idle or done)
//   loop_i        repeat sweeps back to back while high; sampled at the end of each sweep
//   vec_o         stimulus to the gates: bit0=A, bit1=B, bit2=C
//   result_i      gate outputs, asynchronous to clk_i
//   busy_o        sweep in progress
//   done_o        sweep finished; held until the next start or reset
//   pass_o        done_o and no gate ever mismatched
//   fail_mask_o   sticky per-gate mismatch flags
//   first_fail_o  {valid, vec} of the first mismatching vector
//   pass_cnt_o    completed error-free sweeps, saturating at 255

module gate_selftest #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        loop_i,
  output logic [2:0]  vec_o,
  input  logic [15:0] result_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] fail_mask_o,
  output logic [3:0]  first_fail_o,
  output logic [7:0]  pass_cnt_o
);

  // Counter runs SETTLE_CYCLES-1 down to 0, giving SETTLE_CYCLES settle cycles per vector.
  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } state_e;

  state_e      state_q;
  logic [7:0]  settle_cnt_q;
  logic [2:0]  vec_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [15:0] fail_mask_q;
  logic [3:0]  first_fail_q;
  logic [7:0]  pass_cnt_q;
  // Set once any CHECK of the current sweep has mismatched; cleared at each sweep start/wrap.
  logic        sweep_err_q;

  // Two-flop synchroniser for the asynchronous gate outputs.
  logic [15:0] sync1_q;
  logic [15:0] sync2_q;

  logic [15:0] expected;
  logic [15:0] mismatch;
  logic [15:0] mask_next;
  logic        any_mismatch;
  logic        sweep_clean;

  // Ideal truth table of the gate board.
  function automatic logic [15:0] gate_expect(input logic [2:0] v);
    logic        a;
    logic        b;
    logic        c;
    logic [15:0] e;
    a = v[0];
    b = v[1];
    c = v[2];
    e[0]  = a;
    e[1]  = a;
    e[2]  = ~a;
    e[3]  = c ? b : a;
    e[4]  = a & b;
    e[5]  = a & b & c;
    e[6]  = ~(a & b);
    e[7]  = ~(a & b & c);
    e[8]  = a | b;
    e[9]  = a | b | c;
    e[10] = ~(a | b);
    e[11] = ~(a | b | c);
    e[12] = (a & b) | c;
    e[13] = (a | b) & c;
    e[14] = a ^ b;
    e[15] = a ^ b ^ c;
    return e;
  endfunction

  always_comb begin
    expected     = gate_expect(vec_q);
    mismatch     = sync2_q ^ expected;
    any_mismatch = (mismatch != 16'h0000);
    mask_next    = fail_mask_q | mismatch;
    // Only meaningful in the vec 7 CHECK: the whole sweep, including this cycle, was clean.
    sweep_clean  = ~sweep_err_q & ~any_mismatch;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 16'h0000;
      sync2_q <= 16'h0000;
    end else begin
      sync1_q <= result_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      settle_cnt_q <= 8'd0;
      vec_q        <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= 16'h0000;
      first_fail_q <= 4'h0;
      pass_cnt_q   <= 8'd0;
      sweep_err_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q      <= StSettle;
            settle_cnt_q <= SettleLoad;
            vec_q        <= 3'd0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_mask_q  <= 16'h0000;
            first_fail_q <= 4'h0;
            sweep_err_q  <= 1'b0;
          end
        end

        StSettle: begin
          if (settle_cnt_q == 8'd0) begin
            state_q <= StCheck;
          end else begin
            settle_cnt_q <= settle_cnt_q - 8'd1;
          end
        end

        StCheck: begin
          fail_mask_q <= mask_next;
          if (any_mismatch && !first_fail_q[3]) begin
            first_fail_q <= {1'b1, vec_q};
          end

          if (vec_q != 3'd7) begin
            vec_q        <= vec_q + 3'd1;
            settle_cnt_q <= SettleLoad;
            state_q      <= StSettle;
            sweep_err_q  <= sweep_err_q | any_mismatch;
          end else begin
            if (sweep_clean && (pass_cnt_q != 8'hFF)) begin
              pass_cnt_q <= pass_cnt_q + 8'd1;
            end
            sweep_err_q <= 1'b0;
            if (loop_i) begin
              // Mask and first-fail stay sticky across looped sweeps.
              vec_q        <= 3'd0;
              settle_cnt_q <= SettleLoad;
              state_q      <= StSettle;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (mask_next == 16'h0000);
            end
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_o        = vec_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_mask_o  = fail_mask_q;
  assign first_fail_o = first_fail_q;
  assign pass_cnt_o   = pass_cnt_q;

endmodule

// File: doc/gate_selftest.md
GATE_SELFTEST -- requirements
Module: gate_selftest

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, cycles waited after each vector change before sampling; legal range 3..255.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port loop_i  input  1  when high, the sweep repeats until loop_i is sampled low at wrap.
REQ-006 SHALL have port vec_o  output  3  stimulus: bit0=A, bit1=B, bit2=C, driving the gate inputs in place of the DIP switches.
REQ-007 SHALL have port result_i  input  16  gate outputs result[15:0], asynchronous to clk_i.
REQ-008 SHALL have port busy_o  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done_o  output  1  high after a sweep completes; held until the next start or reset.
REQ-010 SHALL have port pass_o  output  1  high with done_o when fail_mask_o is zero.
REQ-011 SHALL have port fail_mask_o  output  16  sticky per-gate mismatch flags.
REQ-012 SHALL have port first_fail_o  output  4  {valid, vec} of the first mismatching vector.
REQ-013 SHALL have port pass_cnt_o  output  8  completed error-free sweeps, saturating at 255.

Function
REQ-014 SHALL synchronise result_i through two flops before comparison.
REQ-015 SHALL compute expected bits from vec_o: 0 A; 1 A; 2 ~A; 3 C?B:A; 4 A&B; 5 A&B&C; 6 ~(A&B); 7 ~(A&B&C); 8 A|B; 9 A|B|C; 10 ~(A|B); 11 ~(A|B|C); 12 (A&B)|C; 13 (A|B)&C; 14 A^B; 15 A^B^C.
REQ-016 SHALL implement the FSM states IDLE, SETTLE, CHECK, DONE.
REQ-017 IDLE: start_i=1 -> SETTLE, vec_o=0, fail_mask_o=0, first_fail_o=0, busy_o=1, done_o=0.
REQ-018 SETTLE: a down-counter loaded with SETTLE_CYCLES-1 on entry; at zero -> CHECK; vec_o held constant.
REQ-019 CHECK (exactly one cycle): fail_mask_o |= (synced result XOR expected); if the mismatch is non-zero and first_fail_o[3]=0, capture {1, vec_o}.
REQ-020 CHECK with vec_o<7 -> vec_o+1, SETTLE; per-vector cost is SETTLE_CYCLES+1 cycles, a full sweep 8*(SETTLE_CYCLES+1).
REQ-021 CHECK with vec_o=7: if the sweep (including this CHECK) was mismatch-free, pass_cnt_o increments, saturating at 255.
REQ-022 CHECK with vec_o=7 and loop_i=1 -> vec_o wraps to 0, SETTLE; fail_mask_o and first_fail_o are retained (sticky across loops).
REQ-023 CHECK with vec_o=7 and loop_i=0 -> DONE; busy_o=0, done_o=1, pass_o=(fail_mask_o==0).
REQ-024 DONE: start_i=1 behaves as in IDLE (clears the mask and first_fail, restarts); pass_cnt_o is not cleared.
REQ-025 start_i SHALL be ignored in SETTLE and CHECK.
REQ-026 pass_o SHALL be 0 whenever done_o=0.

Reset
REQ-027 rst_i=1 SHALL, on the next edge and from any state (including mid-sweep), force IDLE, vec_o=0, busy_o=0, done_o=0, pass_o=0, fail_mask_o=0, first_fail_o=0, pass_cnt_o=0, clear the settle counter and clear the sync flops.
REQ-028 rst_i SHALL take priority over start_i in the same cycle.

Verification
REQ-029 Correct gate model, SETTLE_CYCLES=4, one start pulse -> busy_o for 40 cycles; done_o=1, pass_o=1, fail_mask_o=0x0000, pass_cnt_o=1.
REQ-030 result[6] stuck at 1 -> fail_mask_o=0x0040, first_fail_o=4'b1011 (vec 3), pass_o=0, pass_cnt_o=0.
REQ-031 result[12] stuck at 0 plus result[2] stuck at 0 -> fail_mask_o=0x1004, first_fail_o=4'b1000 (vec 0).
REQ-032 loop_i=1, correct model, 300 sweeps -> pass_cnt_o saturates at 255; dropping loop_i -> DONE at the next vec 7.
REQ-033 rst_i asserted during SETTLE of vec 5 -> next cycle IDLE with all outputs zero; a start pulse coincident with rst_i is ignored.
REQ-034 start_i pulsed mid-sweep -> no effect on vec_o sequence or timing.
